// File: rtl/piso_tx.sv
// AXI4-Lite programmed parallel-in/serial-out transmitter: words pushed into a FIFO
// are shifted out MSB-first on sout with a programmable bit period.
`ifndef AXI4_ADDR_BITS
`define AXI4_ADDR_BITS 32
`endif
`ifndef AXI4_DATA_BITS
`define AXI4_DATA_BITS 32
`endif
`ifndef AXI4_STRB_BITS
`define AXI4_STRB_BITS 4
`endif
`ifndef AXI4_PROT_BITS
`define AXI4_PROT_BITS 3
`endif
`ifndef AXI4_RESP_BITS
`define AXI4_RESP_BITS 2
`endif

// state | meaning
// IDLE  | waiting for en, user_rstn and a non-empty FIFO
// LOAD  | one dead cycle after a pop; counters primed
// SHIFT | driving shreg MSB, DIV+1 cycles per bit
module piso_tx #(
  parameter int PISO_WIDTH = 32,
  parameter int PISO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                         s_axi4lite_clk,
  input  logic                         s_axi4lite_rstn,
  input  logic                         s_axi4lite_aw_valid,
  output logic                         s_axi4lite_aw_ready,
  input  logic [`AXI4_ADDR_BITS-1:0]   s_axi4lite_aw_addr,
  input  logic [`AXI4_PROT_BITS-1:0]   s_axi4lite_aw_prot,
  input  logic                         s_axi4lite_w_valid,
  output logic                         s_axi4lite_w_ready,
  input  logic [`AXI4_DATA_BITS-1:0]   s_axi4lite_w_data,
  input  logic [`AXI4_STRB_BITS-1:0]   s_axi4lite_w_strb,
  output logic                         s_axi4lite_b_valid,
  input  logic                         s_axi4lite_b_ready,
  output logic [`AXI4_RESP_BITS-1:0]   s_axi4lite_b_resp,
  input  logic                         s_axi4lite_ar_valid,
  output logic                         s_axi4lite_ar_ready,
  input  logic [`AXI4_ADDR_BITS-1:0]   s_axi4lite_ar_addr,
  input  logic [`AXI4_PROT_BITS-1:0]   s_axi4lite_ar_prot,
  output logic                         s_axi4lite_r_valid,
  input  logic                         s_axi4lite_r_ready,
  output logic [`AXI4_DATA_BITS-1:0]   s_axi4lite_r_data,
  output logic [`AXI4_RESP_BITS-1:0]   s_axi4lite_r_resp,
  output logic                         sout,
  output logic                         sout_valid
);
  localparam int DW    = `AXI4_DATA_BITS;
  localparam int RW    = `AXI4_RESP_BITS;
  localparam int PTR_W = $clog2(PISO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int BC_W  = $clog2(PISO_WIDTH);
  localparam logic [RW-1:0] OKAY   = RW'(0);
  localparam logic [RW-1:0] SLVERR = RW'(2);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;

  logic                  rst_done_q;
  logic                  aw_pend_q, w_pend_q, rd_pend_q;
  logic [7:0]            aw_addr_q, ar_addr_q;
  logic [DW-1:0]         w_data_q;
  logic                  b_valid_q, r_valid_q;
  logic [RW-1:0]         b_resp_q, r_resp_q;
  logic [DW-1:0]         r_data_q;
  logic                  en_q, user_rstn_q;
  logic [DIV_WIDTH-1:0]  div_cfg_q;

  logic [PISO_WIDTH-1:0] mem_q [PISO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]      level_q;
  logic                  full, empty, push, pop;

  state_e                state_q, state_d;
  logic [PISO_WIDTH-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DIV_WIDTH-1:0]  tick_q, tick_d, div_q, div_d;

  logic                  wr_exec, ctrl_we, div_we;
  logic [RW-1:0]         wr_resp, rd_resp;
  logic [DW-1:0]         rd_data;

  logic unused_bits;
  assign unused_bits = ^{s_axi4lite_aw_prot, s_axi4lite_ar_prot, s_axi4lite_w_strb,
                         s_axi4lite_aw_addr[`AXI4_ADDR_BITS-1:8],
                         s_axi4lite_ar_addr[`AXI4_ADDR_BITS-1:8]};

  assign s_axi4lite_aw_ready = rst_done_q && !aw_pend_q && !b_valid_q;
  assign s_axi4lite_w_ready  = rst_done_q && !w_pend_q && !b_valid_q;
  assign s_axi4lite_ar_ready = rst_done_q && !rd_pend_q && !r_valid_q;
  assign s_axi4lite_b_valid  = b_valid_q;
  assign s_axi4lite_b_resp   = b_resp_q;
  assign s_axi4lite_r_valid  = r_valid_q;
  assign s_axi4lite_r_data   = r_data_q;
  assign s_axi4lite_r_resp   = r_resp_q;

  assign full    = (level_q == LVL_W'(PISO_DEPTH));
  assign empty   = (level_q == '0);
  assign wr_exec = aw_pend_q && w_pend_q;

  always_comb begin
    wr_resp = OKAY;
    push    = 1'b0;
    ctrl_we = 1'b0;
    div_we  = 1'b0;
    case (aw_addr_q)
      8'h00: begin
        if (full) wr_resp = SLVERR;
        else      push    = wr_exec;
      end
      8'h10:   ctrl_we = wr_exec;
      8'h18:   div_we  = wr_exec;
      default: wr_resp = SLVERR;
    endcase
  end

  always_comb begin
    rd_data = '0;
    rd_resp = OKAY;
    case (ar_addr_q)
      8'h00: rd_data = '0;
      8'h08: begin
        rd_data[8 +: LVL_W] = level_q;
        rd_data[4:0]        = {(state_q != IDLE), user_rstn_q, en_q, full, empty};
      end
      8'h10:   rd_data[1:0] = {user_rstn_q, en_q};
      8'h18:   rd_data[DIV_WIDTH-1:0] = div_cfg_q;
      default: rd_resp = SLVERR;
    endcase
  end

  always_ff @(posedge s_axi4lite_clk or negedge s_axi4lite_rstn) begin
    if (!s_axi4lite_rstn) begin
      rst_done_q  <= 1'b0;
      aw_pend_q   <= 1'b0;
      w_pend_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      aw_addr_q   <= '0;
      ar_addr_q   <= '0;
      w_data_q    <= '0;
      b_valid_q   <= 1'b0;
      b_resp_q    <= '0;
      r_valid_q   <= 1'b0;
      r_resp_q    <= '0;
      r_data_q    <= '0;
      en_q        <= 1'b1;
      user_rstn_q <= 1'b1;
      div_cfg_q   <= '0;
    end else begin
      rst_done_q <= 1'b1;
      if (s_axi4lite_aw_valid && s_axi4lite_aw_ready) begin
        aw_pend_q <= 1'b1;
        aw_addr_q <= s_axi4lite_aw_addr[7:0];
      end
      if (s_axi4lite_w_valid && s_axi4lite_w_ready) begin
        w_pend_q <= 1'b1;
        w_data_q <= s_axi4lite_w_data;
      end
      if (wr_exec) begin
        aw_pend_q <= 1'b0;
        w_pend_q  <= 1'b0;
        b_valid_q <= 1'b1;
        b_resp_q  <= wr_resp;
      end else if (b_valid_q && s_axi4lite_b_ready) begin
        b_valid_q <= 1'b0;
      end
      if (ctrl_we) {user_rstn_q, en_q} <= w_data_q[1:0];
      if (div_we)  div_cfg_q <= w_data_q[DIV_WIDTH-1:0];
      if (s_axi4lite_ar_valid && s_axi4lite_ar_ready) begin
        rd_pend_q <= 1'b1;
        ar_addr_q <= s_axi4lite_ar_addr[7:0];
      end
      if (rd_pend_q) begin
        rd_pend_q <= 1'b0;
        r_valid_q <= 1'b1;
        r_data_q  <= rd_data;
        r_resp_q  <= rd_resp;
      end else if (r_valid_q && s_axi4lite_r_ready) begin
        r_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge s_axi4lite_clk) begin
    if (push) mem_q[wr_ptr_q] <= w_data_q[PISO_WIDTH-1:0];
  end

  // user_rstn low keeps the FIFO flushed; it overrides any push or pop
  always_ff @(posedge s_axi4lite_clk or negedge s_axi4lite_rstn) begin
    if (!s_axi4lite_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (!user_rstn_q) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tick_d    = tick_q;
    div_d     = div_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_q && !empty) begin
          pop     = 1'b1;
          shreg_d = mem_q[rd_ptr_q];
          div_d   = div_cfg_q;
          state_d = LOAD;
        end
      end
      LOAD: begin
        bit_cnt_d = BC_W'(PISO_WIDTH - 1);
        tick_d    = div_q;
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (tick_q != '0) begin
          tick_d = tick_q - DIV_WIDTH'(1);
        end else if (bit_cnt_q != '0) begin
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q - BC_W'(1);
          tick_d    = div_q;
        end else if (en_q && !empty) begin
          pop     = 1'b1;
          shreg_d = mem_q[rd_ptr_q];
          div_d   = div_cfg_q;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!user_rstn_q) begin
      pop     = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge s_axi4lite_clk or negedge s_axi4lite_rstn) begin
    if (!s_axi4lite_rstn) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tick_q    <= '0;
      div_q     <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tick_q    <= tick_d;
      div_q     <= div_d;
    end
  end

  assign sout       = (state_q == SHIFT) ? shreg_q[PISO_WIDTH-1] : 1'b0;
  assign sout_valid = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx: AXI register access, serial framing,
// FIFO limits, soft flush and reset abort.
`ifndef AXI4_ADDR_BITS
`define AXI4_ADDR_BITS 32
`endif
`ifndef AXI4_DATA_BITS
`define AXI4_DATA_BITS 32
`endif
`ifndef AXI4_STRB_BITS
`define AXI4_STRB_BITS 4
`endif
`ifndef AXI4_PROT_BITS
`define AXI4_PROT_BITS 3
`endif
`ifndef AXI4_RESP_BITS
`define AXI4_RESP_BITS 2
`endif

module tb_piso_tx;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        aw_valid = 1'b0, aw_ready;
  logic [31:0] aw_addr = '0;
  logic [2:0]  aw_prot = '0;
  logic        w_valid = 1'b0, w_ready;
  logic [31:0] w_data = '0;
  logic [3:0]  w_strb = 4'hF;
  logic        b_valid, b_ready = 1'b0;
  logic [1:0]  b_resp;
  logic        ar_valid = 1'b0, ar_ready;
  logic [31:0] ar_addr = '0;
  logic [2:0]  ar_prot = '0;
  logic        r_valid, r_ready = 1'b0;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        sout, sout_valid;

  int checks = 0;
  int errors = 0;

  piso_tx dut (
    .s_axi4lite_clk(clk), .s_axi4lite_rstn(rstn),
    .s_axi4lite_aw_valid(aw_valid), .s_axi4lite_aw_ready(aw_ready),
    .s_axi4lite_aw_addr(aw_addr), .s_axi4lite_aw_prot(aw_prot),
    .s_axi4lite_w_valid(w_valid), .s_axi4lite_w_ready(w_ready),
    .s_axi4lite_w_data(w_data), .s_axi4lite_w_strb(w_strb),
    .s_axi4lite_b_valid(b_valid), .s_axi4lite_b_ready(b_ready), .s_axi4lite_b_resp(b_resp),
    .s_axi4lite_ar_valid(ar_valid), .s_axi4lite_ar_ready(ar_ready),
    .s_axi4lite_ar_addr(ar_addr), .s_axi4lite_ar_prot(ar_prot),
    .s_axi4lite_r_valid(r_valid), .s_axi4lite_r_ready(r_ready),
    .s_axi4lite_r_data(r_data), .s_axi4lite_r_resp(r_resp),
    .sout(sout), .sout_valid(sout_valid)
  );

  always #5 clk = ~clk;

  // serial monitor: captured bits, valid-run lengths, low-gap lengths before each run
  logic cap[$];
  int   runs[$];
  int   gaps[$];
  int   run_len = 0;
  int   low_len = 0;
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (sout_valid) begin
      cap.push_back(sout);
      if (!prev_v) begin
        gaps.push_back(low_len);
        run_len = 0;
      end
      run_len++;
      low_len = 0;
    end else begin
      if (prev_v) runs.push_back(run_len);
      low_len++;
    end
    prev_v = sout_valid;
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
    int n;
    logic a_hs, d_hs;
    resp = 2'b11;
    @(negedge clk);
    aw_addr = addr; aw_valid = 1'b1;
    w_data = data;  w_valid = 1'b1;
    n = 0;
    while ((aw_valid || w_valid) && n < 50) begin
      a_hs = aw_valid && aw_ready;
      d_hs = w_valid && w_ready;
      @(negedge clk);
      if (a_hs) aw_valid = 1'b0;
      if (d_hs) w_valid = 1'b0;
      n++;
    end
    b_ready = 1'b1;
    n = 0;
    while (!b_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (b_valid) begin
      resp = b_resp;
      @(negedge clk);
    end else begin
      checks++; errors++;
      $display("FAIL axi_write_timeout addr=%h", addr);
      aw_valid = 1'b0; w_valid = 1'b0;
    end
    b_ready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    data = '1; resp = 2'b11;
    @(negedge clk);
    ar_addr = addr; ar_valid = 1'b1;
    n = 0;
    while (!ar_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    ar_valid = 1'b0;
    r_ready = 1'b1;
    n = 0;
    while (!r_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (r_valid) begin
      data = r_data; resp = r_resp;
      @(negedge clk);
    end else begin
      checks++; errors++;
      $display("FAIL axi_read_timeout addr=%h", addr);
    end
    r_ready = 1'b0;
  endtask

  task automatic wait_runs(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (runs.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (runs.size() < n) begin
      checks++; errors++;
      $display("FAIL %s run_timeout got=%0d runs need=%0d", name, runs.size(), n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({aw_ready, w_ready, ar_ready, b_valid, r_valid, sout, sout_valid, b_resp, r_resp, r_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b%b%b bv=%b rv=%b sout=%b sv=%b rdata=%h need all zero",
               aw_ready, w_ready, ar_ready, b_valid, r_valid, sout, sout_valid, r_data);
    end
    rstn = 1'b1;
    @(negedge clk); @(negedge clk);
    axi_read(32'h08, d, r);
    checks++;
    if (d !== 32'h0000_000D || r !== 2'b00) begin
      errors++; $display("FAIL reset_status got=%h/%b need=0000000d/00", d, r);
    end
    axi_read(32'h10, d, r);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL reset_ctrl got=%h need=3", d); end
    axi_read(32'h18, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_div got=%h need=0", d); end
  endtask

  task automatic test_div0();
    logic [31:0] word, d;
    logic [1:0]  r;
    int c0, r0, bad;
    word = 32'hA5A5_0F0F;
    c0 = cap.size(); r0 = runs.size();
    axi_write(32'h00, word, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL div0_bresp got=%b need=00", r); end
    wait_runs(r0 + 1, 200, "div0");
    if (runs.size() > r0) begin
      checks++;
      if (runs[r0] !== 32) begin errors++; $display("FAIL div0_runlen got=%0d need=32", runs[r0]); end
      bad = 0;
      for (int i = 0; i < 32; i++) if (cap[c0 + i] !== word[31 - i]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL div0_bits got=%0d wrong bits need=0", bad); end
    end
    axi_read(32'h08, d, r);
    checks++;
    if (d !== 32'h0000_000D) begin errors++; $display("FAIL div0_status got=%h need=0000000d", d); end
  endtask

  task automatic test_div3();
    logic [1:0] r;
    logic       e;
    int c0, r0, bad;
    axi_write(32'h18, 32'd3, r);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL div3_divwr got=%b need=00", r); end
    c0 = cap.size(); r0 = runs.size();
    axi_write(32'h00, 32'h8000_0001, r);
    wait_runs(r0 + 1, 400, "div3");
    if (runs.size() > r0) begin
      checks++;
      if (runs[r0] !== 128) begin errors++; $display("FAIL div3_runlen got=%0d need=128", runs[r0]); end
      bad = 0;
      for (int i = 0; i < 128; i++) begin
        e = (i < 4) || (i >= 124);
        if (cap[c0 + i] !== e) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL div3_pattern got=%0d wrong cycles need=0", bad); end
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] words [17];
    logic [31:0] d;
    logic [1:0]  r;
    logic [7:0]  ib;
    int c0, r0, g0, bad_resp, bad;
    axi_write(32'h18, 32'd0, r);
    axi_write(32'h10, 32'h2, r);
    bad_resp = 0;
    for (int i = 0; i < 17; i++) begin
      ib = 8'(i);
      words[i] = {8'h5A, ib, 8'hC3, ~ib};
      axi_write(32'h00, words[i], r);
      if (i < 16 && r !== 2'b00) bad_resp++;
      if (i == 16) begin
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL full_17th_resp got=%b need=10", r); end
      end
    end
    checks++;
    if (bad_resp != 0) begin errors++; $display("FAIL full_first16_resp got=%0d non-OKAY need=0", bad_resp); end
    axi_read(32'h08, d, r);
    checks++;
    if (d !== 32'h0000_100A) begin errors++; $display("FAIL full_status got=%h need=0000100a", d); end
    c0 = cap.size(); r0 = runs.size(); g0 = gaps.size();
    axi_write(32'h10, 32'h3, r);
    wait_runs(r0 + 16, 16 * 34 + 100, "full_drain");
    if (runs.size() >= r0 + 16) begin
      bad = 0;
      for (int k = 0; k < 16; k++) if (runs[r0 + k] !== 32) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL drain_runlen got=%0d bad runs need=0", bad); end
      bad = 0;
      for (int k = 1; k < 16; k++) if (gaps[g0 + k] !== 1) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL drain_gap got=%0d bad gaps need=0", bad); end
      bad = 0;
      for (int k = 0; k < 16; k++)
        for (int i = 0; i < 32; i++)
          if (cap[c0 + k * 32 + i] !== words[k][31 - i]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL drain_data got=%0d wrong bits need=0", bad); end
    end
  endtask

  task automatic test_user_rstn();
    logic [31:0] d, word;
    logic [1:0]  r;
    int c0, r0, k;
    axi_write(32'h18, 32'd3, r);
    c0 = cap.size();
    axi_write(32'h00, 32'hFFFF_FFFF, r);
    axi_write(32'h00, 32'hFFFF_FFFF, r);
    k = 0;
    while (cap.size() < c0 + 20 && k < 100) begin @(negedge clk); k++; end
    axi_write(32'h10, 32'h1, r);
    checks++;
    if (sout_valid !== 1'b0 || sout !== 1'b0) begin
      errors++; $display("FAIL flush_sout got sv=%b sout=%b need 0/0", sout_valid, sout);
    end
    axi_read(32'h08, d, r);
    checks++;
    if (d !== 32'h0000_0005) begin errors++; $display("FAIL flush_status got=%h need=00000005", d); end
    axi_write(32'h10, 32'h3, r);
    c0 = cap.size();
    repeat (20) @(negedge clk);
    checks++;
    if (cap.size() != c0) begin errors++; $display("FAIL flush_idle got=%0d bits need=0", cap.size() - c0); end
    axi_read(32'h08, d, r);
    checks++;
    if (d !== 32'h0000_000D) begin errors++; $display("FAIL flush_status2 got=%h need=0000000d", d); end
    axi_write(32'h18, 32'd0, r);
    word = 32'h3C3C_00FF;
    c0 = cap.size(); r0 = runs.size();
    axi_write(32'h00, word, r);
    wait_runs(r0 + 1, 200, "flush_repush");
    if (runs.size() > r0) begin
      k = 0;
      for (int i = 0; i < 32; i++) if (cap[c0 + i] !== word[31 - i]) k++;
      checks++;
      if (k != 0 || runs[r0] !== 32) begin
        errors++; $display("FAIL flush_repush got=%0d wrong bits len=%0d need 0/32", k, runs[r0]);
      end
    end
  endtask

  task automatic test_concurrent();
    logic [31:0] d;
    logic [1:0]  r;
    @(negedge clk);
    checks++;
    if (aw_ready !== 1'b1 || ar_ready !== 1'b1) begin
      errors++; $display("FAIL conc_ready got aw=%b ar=%b need 1/1", aw_ready, ar_ready);
    end
    aw_addr = 32'h18; aw_valid = 1'b1;
    ar_addr = 32'h08; ar_valid = 1'b1;
    @(negedge clk);
    aw_valid = 1'b0; ar_valid = 1'b0;
    checks++;
    if (aw_ready !== 1'b0) begin errors++; $display("FAIL conc_aw_pend got=%b need=0", aw_ready); end
    @(negedge clk);
    @(negedge clk);
    w_data = 32'd5; w_valid = 1'b1;
    checks++;
    if (w_ready !== 1'b1) begin errors++; $display("FAIL conc_w_ready got=%b need=1", w_ready); end
    @(negedge clk);
    w_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (b_valid !== 1'b1 || b_resp !== 2'b00) begin
      errors++; $display("FAIL conc_b got=%b/%b need 1/00", b_valid, b_resp);
    end
    checks++;
    if (r_valid !== 1'b1 || r_data !== 32'h0000_000D || r_resp !== 2'b00) begin
      errors++; $display("FAIL conc_r got=%b/%h/%b need 1/0000000d/00", r_valid, r_data, r_resp);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({b_valid, r_valid, aw_ready, w_ready, ar_ready} !== 5'b11000) begin
      errors++; $display("FAIL conc_hold got=%b need=11000", {b_valid, r_valid, aw_ready, w_ready, ar_ready});
    end
    b_ready = 1'b1; r_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0; r_ready = 1'b0;
    checks++;
    if ({b_valid, r_valid, aw_ready, w_ready} !== 4'b0011) begin
      errors++; $display("FAIL conc_release got=%b need=0011", {b_valid, r_valid, aw_ready, w_ready});
    end
    axi_read(32'h18, d, r);
    checks++;
    if (d !== 32'd5) begin errors++; $display("FAIL conc_div got=%h need=5", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(32'h04, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL unmapped_rd got=%h/%b need 0/10", d, r); end
    axi_read(32'h00, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL txdata_rd got=%h/%b need 0/00", d, r); end
    axi_write(32'h20, 32'hFFFF_FFFF, r);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL unmapped_wr got=%b need=10", r); end
    axi_read(32'h10, d, r);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL unmapped_ctrl got=%h need=3", d); end
    axi_read(32'h18, d, r);
    checks++;
    if (d !== 32'd5) begin errors++; $display("FAIL unmapped_div got=%h need=5", d); end
    axi_read(32'h08, d, r);
    checks++;
    if (d !== 32'h0000_000D) begin errors++; $display("FAIL unmapped_status got=%h need=0000000d", d); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    logic [1:0]  r;
    int c0, k;
    c0 = cap.size();
    axi_write(32'h00, 32'hFFFF_0000, r);
    k = 0;
    while (cap.size() < c0 + 10 && k < 100) begin @(negedge clk); k++; end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (sout_valid !== 1'b0 || sout !== 1'b0 || aw_ready !== 1'b0) begin
      errors++; $display("FAIL areset_abort got sv=%b sout=%b awr=%b need 0/0/0", sout_valid, sout, aw_ready);
    end
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    c0 = cap.size();
    repeat (40) @(negedge clk);
    checks++;
    if (cap.size() != c0) begin errors++; $display("FAIL areset_lost got=%0d bits need=0", cap.size() - c0); end
    axi_read(32'h08, d, r);
    checks++;
    if (d !== 32'h0000_000D) begin errors++; $display("FAIL areset_status got=%h need=0000000d", d); end
    axi_read(32'h18, d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL areset_div got=%h need=0", d); end
  endtask

  initial begin
    test_reset();
    test_div0();
    test_div3();
    test_fifo_full();
    test_user_rstn();
    test_concurrent();
    test_unmapped();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached need finish earlier");
    $fatal(1, "timeout");
  end
endmodule
